// File: rtl/word_store_unit_if.sv
// Write-back bus between the register/ALU side and the 8-bit data memory write port.
// Latency: none (wires only).
// Backpressure: mem_ready qualifies each beat presented with mem_we.
// Ports: request side  start, size, data[15:0], address[15:0]
//        memory side   mem_ready, mem_addr[15:0], mem_data[7:0], mem_we
//        status        busy, done
interface word_store_unit_if;
  logic        start;
  logic        size;
  logic [15:0] data;
  logic [15:0] address;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;

  // Requester / memory model side
  modport master (
    output start, size, data, address, mem_ready,
    input  mem_addr, mem_data, mem_we, busy, done
  );

  // Store unit side
  modport slave (
    input  start, size, data, address, mem_ready,
    output mem_addr, mem_data, mem_we, busy, done
  );
endinterface

// File: rtl/word_store_unit.sv
// Stores a captured 16-bit word as two byte beats (or one beat for byte stores).
// Latency: Done in cycle 3 after Start for words, cycle 2 for bytes, +1 per stalled beat cycle.
// Backpressure: each beat is held stable until mem_ready is seen high at a clock edge.
// Ports: clk_i    rising-edge clock
//        rst_ni   asynchronous active-low reset
//        bus      word_store_unit_if.slave (request, memory beat, busy/done)
module word_store_unit #(
  parameter bit HIGH_FIRST = 1'b0  // word stores: 0 = low byte at base, 1 = high byte at base
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  word_store_unit_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q;
  logic [15:0] addr_q;
  logic        word_q;
  logic        capture;

  // Only state and the captured request are registered; every output is a
  // decode of these, so nothing on the bus reaches an output in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      data_q  <= 16'h0000;
      addr_q  <= 16'h0000;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_q <= bus.data;
        addr_q <= bus.address;
        word_q <= bus.size;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (bus.mem_ready) begin
          state_d = word_q ? S_SECOND : S_DONE;
        end
      end
      S_SECOND: begin
        if (bus.mem_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Start here is deliberately dropped; requests are never queued.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.mem_data = 8'h00;
    case (state_q)
      S_FIRST: begin
        bus.mem_we   = 1'b1;
        bus.busy     = 1'b1;
        bus.mem_addr = addr_q;
        // Byte stores always send the low byte regardless of beat order.
        bus.mem_data = (HIGH_FIRST && word_q) ? data_q[15:8] : data_q[7:0];
      end
      S_SECOND: begin
        bus.mem_we   = 1'b1;
        bus.busy     = 1'b1;
        bus.mem_addr = addr_q + 16'd1;  // wraps 0xFFFF -> 0x0000
        bus.mem_data = HIGH_FIRST ? data_q[7:0] : data_q[15:8];
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_store_unit.sv
// Directed bench for word_store_unit: one instance per beat order.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Observed vector layout: {mem_we, busy, done, mem_addr[15:0], mem_data[7:0]}.
module tb_word_store_unit;

  logic clk;
  logic rst_n;
  logic sel;           // 0 = low-first instance, 1 = high-first instance
  int   checks;
  int   errors;
  int   done_cnt0;
  logic [26:0] obs;
  logic [26:0] exp;

  word_store_unit_if if0 ();
  word_store_unit_if if1 ();

  word_store_unit #(.HIGH_FIRST(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
  word_store_unit #(.HIGH_FIRST(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = sel ? {if1.mem_we, if1.busy, if1.done, if1.mem_addr, if1.mem_data}
                   : {if0.mem_we, if0.busy, if0.done, if0.mem_addr, if0.mem_data};

  always @(posedge clk) begin
    if (if0.done) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic s, input logic [15:0] d, input logic [15:0] a,
                         input logic sz, input logic rdy);
    if0.start = s & ~sel;
    if1.start = s & sel;
    if0.data = d;    if1.data = d;
    if0.address = a; if1.address = a;
    if0.size = sz;   if1.size = sz;
    if0.mem_ready = rdy; if1.mem_ready = rdy;
  endtask

  task automatic set_ready(input logic rdy);
    if0.mem_ready = rdy;
    if1.mem_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 1'b0;
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2;
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_lowfirst: got %h expected %h", obs, exp); end
    sel = 1'b1;
    #1;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_highfirst: got %h expected %h", obs, exp); end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_word_low();
    sel = 1'b0;
    set_req(1'b1, 16'hA5C3, 16'h0010, 1'b1, 1'b1);
    cyc();
    // Changing the request after capture must not affect the transfer.
    set_req(1'b0, 16'h0000, 16'h7777, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 16'h0010, 8'hC3};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL word_low_c1: got %h expected %h", obs, exp); end
    cyc();
    exp = {1'b1, 1'b1, 1'b0, 16'h0011, 8'hA5};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL word_low_c2: got %h expected %h", obs, exp); end
    cyc();
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL word_low_c3_done: got %h expected %h", obs, exp); end
    cyc();
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL word_low_c4_idle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_word_high_stall_wrap();
    sel = 1'b1;
    set_req(1'b1, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    exp = {1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h12};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c1_first: got %h expected %h", obs, exp); end
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c2_stall: got %h expected %h", obs, exp); end
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c3_stall: got %h expected %h", obs, exp); end
    set_ready(1'b1);
    cyc();
    set_ready(1'b0);
    exp = {1'b1, 1'b1, 1'b0, 16'h0000, 8'h34};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c4_second_wrap: got %h expected %h", obs, exp); end
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c5_stall: got %h expected %h", obs, exp); end
    set_ready(1'b1);
    cyc();
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c6_done: got %h expected %h", obs, exp); end
    cyc();
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL high_c7_idle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_byte();
    sel = 1'b0;
    set_req(1'b1, 16'hBEEF, 16'h0200, 1'b0, 1'b1);
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 16'h0200, 8'hEF};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL byte_c1: got %h expected %h", obs, exp); end
    cyc();
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL byte_c2_done: got %h expected %h", obs, exp); end
    cyc();
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL byte_c3_no_second: got %h expected %h", obs, exp); end
    // Byte store on the high-first instance still sends the low byte.
    sel = 1'b1;
    set_req(1'b1, 16'hBEEF, 16'h0200, 1'b0, 1'b1);
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 16'h0200, 8'hEF};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL byte_high_c1: got %h expected %h", obs, exp); end
    cyc();
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL byte_high_c2_done: got %h expected %h", obs, exp); end
    cyc();
  endtask

  task automatic test_start_ignored();
    int d0;
    sel = 1'b0;
    d0 = done_cnt0;
    set_req(1'b1, 16'h0102, 16'h0040, 1'b1, 1'b1);
    cyc();
    set_req(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);   // Start during FIRST
    exp = {1'b1, 1'b1, 1'b0, 16'h0040, 8'h02};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ign_c1: got %h expected %h", obs, exp); end
    cyc();
    set_req(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 16'h0041, 8'h01};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ign_c2: got %h expected %h", obs, exp); end
    cyc();
    set_req(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);   // Start during DONE
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ign_c3_done: got %h expected %h", obs, exp); end
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ign_c4_idle: got %h expected %h", obs, exp); end
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ign_c5_idle: got %h expected %h", obs, exp); end
    checks++;
    if (done_cnt0 - d0 !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt0 - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    sel = 1'b0;
    set_req(1'b1, 16'h5678, 16'h0100, 1'b1, 1'b1);
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    cyc();
    exp = {1'b1, 1'b1, 1'b0, 16'h0101, 8'h56};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_second: got %h expected %h", obs, exp); end
    d0 = done_cnt0;
    #2;
    rst_n = 1'b0;
    #1;
    exp = 27'h0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_async_clear: got %h expected %h", obs, exp); end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_after_release: got %h expected %h", obs, exp); end
    checks++;
    if (done_cnt0 - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt0 - d0); end
    set_req(1'b1, 16'h0099, 16'h0300, 1'b0, 1'b1);
    cyc();
    set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 16'h0300, 8'h99};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_restart_c1: got %h expected %h", obs, exp); end
    cyc();
    exp = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_restart_done: got %h expected %h", obs, exp); end
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_cnt0 = 0;
    test_reset();
    test_word_low();
    test_word_high_stall_wrap();
    test_byte();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
